// File: rtl/bcd_stopwatch_if.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_if
//   Bundles the stopwatch control inputs and the count/status outputs so a
//   controller (master) and the stopwatch core (slave) connect through one
//   port each.
//
//   Parameter DIGITS : number of BCD digits carried on the value buses.
//
//   Signals (direction as seen by the stopwatch core / slave modport):
//     Run         in   level, prescaler advances while high
//     Clear       in   one-cycle synchronous clear
//     Load        in   one-cycle synchronous preload
//     Load_Value  in   packed BCD preload value, digit k at [4k+3:4k]
//     Down        in   level, 0 = count up, 1 = count down
//     Lap         in   one-cycle lap capture        (STOPWATCH_LAP_EN only)
//     Number_Sig  out  registered live count, packed BCD
//     Lap_Number  out  registered lap snapshot     (STOPWATCH_LAP_EN only)
//     Wrap_Pulse  out  one-cycle pulse on up-count rollover to all-0s
//     Zero_Pulse  out  one-cycle pulse when a down-count reaches all-0s
//
//   Build option: define STOPWATCH_LAP_EN to include the lap signals.
// ---------------------------------------------------------------------------
interface bcd_stopwatch_if #(
   parameter int DIGITS = 6
);
   logic                  Run;
   logic                  Clear;
   logic                  Load;
   logic [4*DIGITS-1:0]   Load_Value;
   logic                  Down;
   logic [4*DIGITS-1:0]   Number_Sig;
   logic                  Wrap_Pulse;
   logic                  Zero_Pulse;
`ifdef STOPWATCH_LAP_EN
   logic                  Lap;
   logic [4*DIGITS-1:0]   Lap_Number;

   modport master (
      output Run, Clear, Load, Load_Value, Down, Lap,
      input  Number_Sig, Lap_Number, Wrap_Pulse, Zero_Pulse
   );

   modport slave (
      input  Run, Clear, Load, Load_Value, Down, Lap,
      output Number_Sig, Lap_Number, Wrap_Pulse, Zero_Pulse
   );
`else
   modport master (
      output Run, Clear, Load, Load_Value, Down,
      input  Number_Sig, Wrap_Pulse, Zero_Pulse
   );

   modport slave (
      input  Run, Clear, Load, Load_Value, Down,
      output Number_Sig, Wrap_Pulse, Zero_Pulse
   );
`endif
endinterface

// File: rtl/bcd_stopwatch.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch
//   Parametrised BCD stopwatch / countdown timer. CLK is divided into a
//   count tick of TICK_DIV cycles; on each tick the DIGITS-wide packed BCD
//   count steps up or down with a full single-cycle carry/borrow ripple.
//   Digit 0 is the least significant (0.1 s at default settings).
//
//   Parameters:
//     TICK_DIV  CLK cycles per count tick (>= 2), default 5_000_000
//     DIGITS    number of BCD digits (1..8), default 6
//
//   Ports:
//     CLK   in  system clock, rising edge
//     RSTn  in  asynchronous active-low reset
//     bus   slave side of bcd_stopwatch_if (controls in, count/pulses out)
//
//   Per-cycle priority: Clear > Load > tick. Up-count wraps all-9s -> all-0s
//   with Wrap_Pulse; down-count stops at zero with Zero_Pulse on arrival.
//
//   Build option: STOPWATCH_LAP_EN adds the Lap input and the Lap_Number
//   snapshot register.
// ---------------------------------------------------------------------------
module bcd_stopwatch #(
   parameter int TICK_DIV = 5_000_000,
   parameter int DIGITS   = 6
) (
   input  logic           CLK,
   input  logic           RSTn,
   bcd_stopwatch_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]   pre_reg;
   logic [W-1:0]    count_reg;
   logic            wrap_pulse_reg;
   logic            zero_pulse_reg;

   logic            tick;
   logic [DIGITS:0] carry_up;
   logic [DIGITS:0] borrow_dn;
   logic [W-1:0]    inc_value;
   logic [W-1:0]    dec_value;
   logic [W-1:0]    load_sat;
   logic            all_nines;
   logic            count_zero;
   logic            dec_zero;

   assign tick = bus.Run && (pre_reg == PRE_LAST);

   // Per-digit increment/decrement and load saturation. carry_up[k] is high
   // when every digit below k is 9 (so digit k receives a carry); borrow_dn[k]
   // is high when every digit below k is 0 (so digit k receives a borrow).
   assign carry_up[0]  = 1'b1;
   assign borrow_dn[0] = 1'b1;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic [3:0] lv;

      assign d  = count_reg[4*gi +: 4];
      assign lv = bus.Load_Value[4*gi +: 4];

      assign carry_up[gi+1]  = carry_up[gi] & (d == 4'd9);
      assign borrow_dn[gi+1] = borrow_dn[gi] & (d == 4'd0);

      assign inc_value[4*gi +: 4] = !carry_up[gi]  ? d :
                                    (d == 4'd9)    ? 4'd0 : d + 4'd1;
      assign dec_value[4*gi +: 4] = !borrow_dn[gi] ? d :
                                    (d == 4'd0)    ? 4'd9 : d - 4'd1;

      // Non-BCD nibbles clamp to 9 so the count can never hold an invalid digit.
      assign load_sat[4*gi +: 4]  = (lv > 4'd9) ? 4'd9 : lv;
   end

   assign all_nines  = carry_up[DIGITS];
   assign count_zero = borrow_dn[DIGITS];
   assign dec_zero   = (dec_value == '0);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pre_reg        <= '0;
         count_reg      <= '0;
         wrap_pulse_reg <= 1'b0;
         zero_pulse_reg <= 1'b0;
      end else begin
         wrap_pulse_reg <= 1'b0;
         zero_pulse_reg <= 1'b0;
         if (bus.Clear) begin
            count_reg <= '0;
            pre_reg   <= '0;
         end else if (bus.Load) begin
            count_reg <= load_sat;
            pre_reg   <= '0;
         end else if (bus.Run) begin
            if (tick) begin
               pre_reg <= '0;
               if (!bus.Down) begin
                  count_reg      <= inc_value;
                  wrap_pulse_reg <= all_nines;
               end else if (!count_zero) begin
                  // Down-count parks at zero; no borrow past all-0s.
                  count_reg      <= dec_value;
                  zero_pulse_reg <= dec_zero;
               end
            end else begin
               pre_reg <= pre_reg + 1'b1;
            end
         end
         // Run low: prescaler and count hold so a pause loses no partial tick.
      end
   end

   assign bus.Number_Sig = count_reg;
   assign bus.Wrap_Pulse = wrap_pulse_reg;
   assign bus.Zero_Pulse = zero_pulse_reg;

`ifdef STOPWATCH_LAP_EN
   logic [W-1:0] lap_reg;

   // Snapshot takes the pre-update count; Clear overrides a coincident Lap.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         lap_reg <= '0;
      end else if (bus.Clear) begin
         lap_reg <= '0;
      end else if (bus.Lap) begin
         lap_reg <= count_reg;
      end
   end

   assign bus.Lap_Number = lap_reg;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch
//   Drives bcd_stopwatch (TICK_DIV=4, DIGITS=3) with directed scenarios and
//   randomized control traffic; a reference model holds the count as a plain
//   integer and the prescaler phase as a cycle counter, and every output is
//   compared after each clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch;
   localparam int TICK_DIV = 4;
   localparam int DIGITS   = 3;
   localparam int W        = 4 * DIGITS;
   localparam int MODV     = 1000;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;

   bcd_stopwatch_if #(.DIGITS(DIGITS)) bus ();

   bcd_stopwatch #(
      .TICK_DIV (TICK_DIV),
      .DIGITS   (DIGITS)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int m_val   = 0;
   int m_phase = 0;
   int m_lap   = 0;
   bit m_wrap  = 1'b0;
   bit m_zero  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int sat_value(input logic [W-1:0] v);
      int r, p, d;
      r = 0;
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         d = int'(v[4*k +: 4]);
         if (d > 9) d = 9;
         r = r + d * p;
         p = p * 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_val = 0; m_phase = 0; m_lap = 0; m_wrap = 1'b0; m_zero = 1'b0;
   endtask

   // Advances the model by one clock edge using the inputs presented to it.
   task automatic model_edge();
      int old_val;
      old_val = m_val;
      m_wrap  = 1'b0;
      m_zero  = 1'b0;
      if (bus.Clear) begin
         m_val = 0; m_phase = 0; m_lap = 0;
      end else begin
`ifdef STOPWATCH_LAP_EN
         if (bus.Lap) m_lap = old_val;
`endif
         if (bus.Load) begin
            m_val   = sat_value(bus.Load_Value);
            m_phase = 0;
         end else if (bus.Run) begin
            if (m_phase == TICK_DIV - 1) begin
               m_phase = 0;
               if (!bus.Down) begin
                  if (old_val == MODV - 1) begin
                     m_val  = 0;
                     m_wrap = 1'b1;
                  end else begin
                     m_val = old_val + 1;
                  end
               end else if (old_val > 0) begin
                  m_val  = old_val - 1;
                  m_zero = (m_val == 0);
               end
            end else begin
               m_phase++;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("num",  32'(bus.Number_Sig), 32'(to_bcd(m_val)));
      chk("wrap", 32'(bus.Wrap_Pulse), 32'(m_wrap));
      chk("zero", 32'(bus.Zero_Pulse), 32'(m_zero));
`ifdef STOPWATCH_LAP_EN
      chk("lap",  32'(bus.Lap_Number), 32'(to_bcd(m_lap)));
`endif
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic pulse_load(input logic [W-1:0] v);
      bus.Load       = 1'b1;
      bus.Load_Value = v;
      step();
      bus.Load       = 1'b0;
   endtask

   // Edges until Number_Sig changes, bounded so a stuck count still finishes.
   task automatic edges_until_change(output int n);
      logic [W-1:0] start;
      start = bus.Number_Sig;
      n = 0;
      while (n < 20) begin
         step();
         n++;
         if (bus.Number_Sig !== start) break;
      end
   endtask

   // Asynchronous reset issued mid-cycle, away from any clock edge.
   task automatic async_reset();
      RSTn = 1'b0;
      #2;
      model_reset();
      compare_all();
      RSTn = 1'b1;
   endtask

   int n;

   initial begin
      bus.Run = 1'b0; bus.Clear = 1'b0; bus.Load = 1'b0;
      bus.Load_Value = '0; bus.Down = 1'b0;
`ifdef STOPWATCH_LAP_EN
      bus.Lap = 1'b0;
`endif
      // Reset values
      repeat (2) @(posedge CLK);
      #1;
      model_reset();
      compare_all();
      @(negedge CLK);
      RSTn = 1'b1;
      step();
      $display("[TB] reset values checked");

      // Up-count: first change 4 edges after Run rises, 0x010 after 40 edges
      bus.Run = 1'b1;
      edges_until_change(n);
      chk("first_tick_latency", n, 4);
      repeat (36) step();
      chk("up40", 32'(bus.Number_Sig), 32'h010);
      $display("[TB] up-count 40 cycles -> %0h", bus.Number_Sig);

      // Wrap from 0x999
      pulse_load(12'h998);
      repeat (4) step();
      chk("pre_wrap", 32'(bus.Number_Sig), 32'h999);
      repeat (4) step();
      chk("wrap_num", 32'(bus.Number_Sig), 32'h000);
      chk("wrap_pulse", 32'(bus.Wrap_Pulse), 32'd1);
      step();
      chk("wrap_width", 32'(bus.Wrap_Pulse), 32'd0);
      $display("[TB] wrap 998->999->000 checked");

      // Down-count to zero, then hold
      bus.Down = 1'b1;
      pulse_load(12'h002);
      repeat (4) step();
      chk("down_one", 32'(bus.Number_Sig), 32'h001);
      repeat (4) step();
      chk("down_zero", 32'(bus.Number_Sig), 32'h000);
      chk("zero_pulse", 32'(bus.Zero_Pulse), 32'd1);
      repeat (9) begin
         step();
         chk("zero_hold_pulse", 32'(bus.Zero_Pulse), 32'd0);
      end
      chk("zero_hold", 32'(bus.Number_Sig), 32'h000);
      bus.Down = 1'b0;
      $display("[TB] down-count to zero and hold checked");

      // Pause mid-period at pre=2
      bus.Run = 1'b0;
      pulse_load(12'h100);
      bus.Run = 1'b1;
      repeat (2) step();
      bus.Run = 1'b0;
      repeat (10) step();
      chk("pause_hold", 32'(bus.Number_Sig), 32'h100);
      bus.Run = 1'b1;
      edges_until_change(n);
      chk("resume_latency", n, 2);
      $display("[TB] pause/resume checked");

      // Load saturation, then Clear+Load together
      pulse_load(12'hA5F);
      chk("load_sat", 32'(bus.Number_Sig), 32'h959);
      bus.Clear = 1'b1;
      pulse_load(12'h321);
      bus.Clear = 1'b0;
      chk("clear_wins", 32'(bus.Number_Sig), 32'h000);
      edges_until_change(n);
      chk("clear_restart", n, 4);
      $display("[TB] load saturation and clear priority checked");

`ifdef STOPWATCH_LAP_EN
      // Lap on the tick edge captures the pre-tick count
      pulse_load(12'h012);
      repeat (3) step();
      bus.Lap = 1'b1;
      step();
      bus.Lap = 1'b0;
      chk("lap_snapshot", 32'(bus.Lap_Number), 32'h012);
      chk("lap_live", 32'(bus.Number_Sig), 32'h013);
      $display("[TB] lap capture checked");
`endif

      // Asynchronous reset mid-count
      repeat (2) step();
      async_reset();
      edges_until_change(n);
      chk("post_reset_latency", n, 4);
      $display("[TB] async reset mid-count checked");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.Run   = ($urandom_range(7) != 0);
         bus.Clear = ($urandom_range(99) == 0);
         bus.Load  = ($urandom_range(39) == 0);
         case ($urandom_range(3))
            0: bus.Load_Value = W'($urandom);
            1: bus.Load_Value = {8'h99, 4'($urandom_range(15))};
            2: bus.Load_Value = {8'h00, 4'($urandom_range(3))};
            default: bus.Load_Value = W'($urandom_range(12'h999));
         endcase
         if ($urandom_range(59) == 0) bus.Down = ~bus.Down;
`ifdef STOPWATCH_LAP_EN
         bus.Lap = ($urandom_range(9) == 0);
`endif
         if ($urandom_range(999) == 0) async_reset();
         step();
      end
      $display("[TB] randomized traffic done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends on its own.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised BCD stopwatch/countdown timer that generalises the team's fixed 6-digit 100 ms up-counter. It divides CLK into a configurable tick, keeps a DIGITS-wide packed BCD count with a single-cycle full carry/borrow ripple, and adds run/pause, clear, preload, count-down with terminal detection and optional lap capture. It feeds the seven-segment display driver directly: digit 0 is the least significant, 0.1 s at default settings.

## Interface
Parameters:
- TICK_DIV, default 5_000_000: CLK cycles per count tick (100 ms at 50 MHz); legal range ≥ 2.
- DIGITS, default 6: number of BCD digits; legal range 1..8.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Run  in  1  level; when high, the prescaler advances; when low, the prescaler and count hold.
- Clear  in  1  one-cycle pulse; synchronous clear.
- Load  in  1  one-cycle pulse; synchronous preload.
- Load_Value  in  4*DIGITS  packed BCD preload value; digit k is [4k+3:4k].
- Down  in  1  level; 0 = count up, 1 = count down.
- Lap  in  1  one-cycle pulse; lap capture. Present only with STOPWATCH_LAP_EN.
- Number_Sig  out  4*DIGITS  registered live count, packed BCD.
- Lap_Number  out  4*DIGITS  registered lap snapshot. Present only with STOPWATCH_LAP_EN.
- Wrap_Pulse  out  1  one-cycle pulse when an up-count rolls over from all-9s to all-0s.
- Zero_Pulse  out  1  one-cycle pulse when a down-count reaches all-0s.

## Operation
- **Prescaler:** `pre` is $clog2(TICK_DIV) bits wide.
  - It counts 0..TICK_DIV-1 only while Run=1.
  - `tick` = Run && (pre == TICK_DIV-1); `pre` then returns to 0.
  - When Run=0, `pre` holds its value, so pause/resume loses no partial tick.
- **Priority per cycle:** Clear > Load > tick.
  - **Clear:** Number_Sig←0, pre←0, Lap_Number←0. No pulses.
  - **Load:** Number_Sig←Load_Value with each digit >9 saturated to 9, pre←0. No pulses.
- **Tick with Down=0:** Number_Sig ← BCD(Number_Sig+1).
  - Full carry ripple through all digits in the same cycle; digit 9→0 carries.
  - From all-9s the count goes to all-0s and Wrap_Pulse=1 for that cycle.
- **Tick with Down=1, count ≠ 0:** Number_Sig ← BCD(Number_Sig−1).
  - Digit 0→9 borrows.
  - If the result is all-0s, Zero_Pulse=1 for that cycle.
- **Tick with Down=1, count = 0:** count holds at 0, no pulse. There is no down-wrap.
- **Invalid internal digits:** impossible by construction. Load saturation guarantees every digit stays in 0..9.
- **Down changes:** a change in Down takes effect at the next tick. The prescaler is unaffected.
- **Lap (STOPWATCH_LAP_EN only):**
  - Lap_Number ← Number_Sig value *before* any same-cycle update.
  - If Lap coincides with Load or tick, it captures the old count.
  - If Lap coincides with Clear, Clear wins and Lap_Number←0.

## Timing
- **Reset values:** Number_Sig=0, Lap_Number=0, Wrap_Pulse=0, Zero_Pulse=0, pre=0.
- **RSTn mid-count:** all state clears immediately (asynchronous). The first tick after release occurs TICK_DIV cycles after the first edge with Run=1.
- **Tick latency:** Number_Sig updates on the same edge on which `tick` is true. Wrap_Pulse and Zero_Pulse are registered and high in the cycle following that edge, aligned with the new count.
- **Clear/Load/Lap latency:** sampled at edge N; the corresponding output reflects the action after edge N.
- **Tick period:** exactly TICK_DIV cycles between successive count changes while Run stays high. Load/Clear restart a full TICK_DIV period.
- **Pulse width:** Wrap_Pulse and Zero_Pulse are exactly 1 cycle and are never asserted together.

## Configuration
- Macro STOPWATCH_LAP_EN.
- **Defined:** the Lap port, the Lap_Number register and the capture logic exist as described above.
- **Undefined:** the Lap and Lap_Number ports are absent, no snapshot register is built, and all other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=4, DIGITS=3, with the lap macro defined unless stated.

- Reset, then Run=1, Down=0 for 40 cycles → Number_Sig = 0x010. Changes occur exactly every 4 cycles; the first change arrives 4 cycles after Run rises.
- Load 0x998, Run=1, Down=0 → 0x999 after 4 cycles, then 0x000 after 4 more with Wrap_Pulse high for exactly 1 cycle.
- Load 0x002, Down=1, Run=1 → 0x001, then 0x000 with Zero_Pulse for 1 cycle; 8 further cycles → still 0x000, with no further pulse.
- Run pulsed low for 10 cycles mid-period (pre=2), then high → the next change occurs 2 cycles after resume; the count is unchanged during the pause.
- Load_Value=0xA5F → Number_Sig=0x959. Clear and Load asserted in the same cycle → 0x000 and pre=0.
- Count reaches 0x012 and Lap is asserted on the tick edge → Lap_Number=0x012, Number_Sig=0x013. With the macro undefined, the build has no Lap ports and all scenarios above except this one pass unchanged.
